// File: rtl/cpu_pkg.sv
// Definitions shared by the fetch and decode stages: instruction width,
// NOP encoding and default geometry.
package cpu_pkg;

  localparam int INSTR_WIDTH      = 16;
  localparam int PC_WIDTH_DEFAULT = 16;
  localparam int IMEM_AW_DEFAULT  = 10;

  typedef logic [INSTR_WIDTH-1:0] instr_t;

  localparam instr_t NOP_INSTR = 16'h0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Control, imem-load and IF/ID output bundle of the fetch stage.
// The master drives controls and the load port; the slave is the fetch stage.
interface fetch_stage_if #(
  parameter int PC_WIDTH = 16,
  parameter int IMEM_AW  = 10
);
  import cpu_pkg::*;

  logic                stall;
  logic                flush;
  logic                branch_taken;
  logic [PC_WIDTH-1:0] branch_target;
  logic                imem_wr_en;
  logic [IMEM_AW-1:0]  imem_wr_addr;
  instr_t              imem_wr_data;
  instr_t              instruction;
  logic [PC_WIDTH-1:0] pc_out;
  logic                valid;

  modport master (
    output stall, flush, branch_taken, branch_target,
    output imem_wr_en, imem_wr_addr, imem_wr_data,
    input  instruction, pc_out, valid
  );

  modport slave (
    input  stall, flush, branch_taken, branch_target,
    input  imem_wr_en, imem_wr_addr, imem_wr_data,
    output instruction, pc_out, valid
  );

endinterface

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: synchronous write, combinational read.
// Contents are never reset so a program loaded during reset survives it.
module instruction_memory
  import cpu_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  instr_t        wr_data,
  input  logic [AW-1:0] rd_addr,
  output instr_t        rd_data
);

  instr_t mem_r [0:(1<<AW)-1];

  // Load port; a same-cycle read of this address still sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: program counter, instruction memory and the IF/ID
// register, with stall, flush and branch redirection.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH = PC_WIDTH_DEFAULT,
  parameter int                  IMEM_AW  = IMEM_AW_DEFAULT,
  parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.slave  bus
);

  localparam logic [PC_WIDTH-1:0] PC_ZERO = {PC_WIDTH{1'b0}};
  localparam logic [PC_WIDTH-1:0] PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  logic [PC_WIDTH-1:0] pc_r;
  logic [PC_WIDTH-1:0] pc_inc_s;
  instr_t              rd_data_s;
  instr_t              instr_r;
  logic [PC_WIDTH-1:0] pc_out_r;
  logic                valid_r;

  instruction_memory #(
    .AW (IMEM_AW)
  ) u_imem (
    .clk     (clk),
    .wr_en   (bus.imem_wr_en),
    .wr_addr (bus.imem_wr_addr),
    .wr_data (bus.imem_wr_data),
    .rd_addr (pc_r[IMEM_AW-1:0]),
    .rd_data (rd_data_s)
  );

  // Wraps modulo 2^PC_WIDTH, so the link value after all-ones is zero.
  assign pc_inc_s = pc_r + PC_ONE;

  // PC and IF/ID register; branch beats flush, which beats stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r     <= RESET_PC;
      instr_r  <= NOP_INSTR;
      pc_out_r <= PC_ZERO;
      valid_r  <= 1'b0;
    end else if (bus.branch_taken) begin
      pc_r     <= bus.branch_target;
      instr_r  <= NOP_INSTR;
      pc_out_r <= PC_ZERO;
      valid_r  <= 1'b0;
    end else if (bus.flush) begin
      pc_r     <= bus.stall ? pc_r : pc_inc_s;
      instr_r  <= NOP_INSTR;
      pc_out_r <= PC_ZERO;
      valid_r  <= 1'b0;
    end else if (bus.stall) begin
      pc_r     <= pc_r;
      instr_r  <= instr_r;
      pc_out_r <= pc_out_r;
      valid_r  <= valid_r;
    end else begin
      pc_r     <= pc_inc_s;
      instr_r  <= rd_data_s;
      pc_out_r <= pc_inc_s;
      valid_r  <= 1'b1;
    end
  end

  assign bus.instruction = instr_r;
  assign bus.pc_out      = pc_out_r;
  assign bus.valid       = valid_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: program load, stall, branch, flush,
// asynchronous reset, write/fetch collision and PC wrap-around.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  fetch_stage_if #(.PC_WIDTH(16), .IMEM_AW(10)) bus ();

  fetch_stage #(
    .PC_WIDTH (16),
    .IMEM_AW  (10),
    .RESET_PC (16'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] ins,
                     input logic [15:0] pco, input logic v);
    total++;
    assert (bus.instruction === ins && bus.pc_out === pco && bus.valid === v)
      passed++;
    else
      $error("FAIL %s: got instr=%h pc_out=%h valid=%b, want instr=%h pc_out=%h valid=%b",
             tag, bus.instruction, bus.pc_out, bus.valid, ins, pco, v);
  endtask

  task automatic load(input logic [9:0] a, input logic [15:0] d);
    bus.imem_wr_en   = 1'b1;
    bus.imem_wr_addr = a;
    bus.imem_wr_data = d;
    cyc();
  endtask

  initial begin
    total  = 0;
    passed = 0;
    reset  = 1'b1;
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 16'h0000;
    bus.imem_wr_en    = 1'b0;
    bus.imem_wr_addr  = 10'd0;
    bus.imem_wr_data  = 16'h0000;

    // program load while held in reset
    load(10'h000, 16'h6001);
    load(10'h001, 16'h2002);
    load(10'h002, 16'h6003);
    load(10'h003, 16'h7004);
    load(10'h004, 16'h7005);
    load(10'h005, 16'h7006);
    load(10'h040, 16'hABCD);
    load(10'h3FF, 16'h5555);
    bus.imem_wr_en = 1'b0;
    chk("reset_state", 16'h0000, 16'h0000, 1'b0);

    reset = 1'b0;
    cyc(); chk("fetch0", 16'h6001, 16'h0001, 1'b1);
    cyc(); chk("fetch1", 16'h2002, 16'h0002, 1'b1);

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("stall_hold", 16'h2002, 16'h0002, 1'b1);
    end
    bus.stall = 1'b0;
    cyc(); chk("after_stall", 16'h6003, 16'h0003, 1'b1);

    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0040;
    cyc(); chk("branch_bubble", 16'h0000, 16'h0000, 1'b0);
    bus.branch_taken = 1'b0;
    cyc(); chk("branch_target", 16'hABCD, 16'h0041, 1'b1);

    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0002;
    bus.stall         = 1'b1;
    cyc(); chk("branch_stall_bubble", 16'h0000, 16'h0000, 1'b0);
    bus.branch_taken = 1'b0;
    bus.stall        = 1'b0;
    cyc(); chk("branch_stall_target", 16'h6003, 16'h0003, 1'b1);

    // flush drops imem[3]; PC still advances to 4
    bus.flush = 1'b1;
    cyc(); chk("flush_bubble", 16'h0000, 16'h0000, 1'b0);
    bus.flush = 1'b0;
    cyc(); chk("after_flush", 16'h7005, 16'h0005, 1'b1);

    // flush with stall: bubble, PC holds at 5
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    cyc(); chk("flush_stall_bubble", 16'h0000, 16'h0000, 1'b0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    cyc(); chk("after_flush_stall", 16'h7006, 16'h0006, 1'b1);

    // asynchronous reset mid-cycle with a pending branch
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0040;
    #2 reset = 1'b1;
    #1 chk("async_reset", 16'h0000, 16'h0000, 1'b0);
    cyc(); chk("reset_held", 16'h0000, 16'h0000, 1'b0);
    reset            = 1'b0;
    bus.branch_taken = 1'b0;
    cyc(); chk("restart0", 16'h6001, 16'h0001, 1'b1);
    cyc(); chk("restart1", 16'h2002, 16'h0002, 1'b1);

    // write to the address being fetched returns the old word
    bus.imem_wr_en   = 1'b1;
    bus.imem_wr_addr = 10'h002;
    bus.imem_wr_data = 16'hBEEF;
    cyc(); chk("write_collision", 16'h6003, 16'h0003, 1'b1);
    bus.imem_wr_en    = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0002;
    cyc(); chk("refetch_bubble", 16'h0000, 16'h0000, 1'b0);
    bus.branch_taken = 1'b0;
    cyc(); chk("refetch_new", 16'hBEEF, 16'h0003, 1'b1);

    // PC wrap: 0xFFFF aliases to imem[0x3FF], then wraps to 0
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'hFFFF;
    cyc(); chk("wrap_bubble", 16'h0000, 16'h0000, 1'b0);
    bus.branch_taken = 1'b0;
    cyc(); chk("wrap_top", 16'h5555, 16'h0000, 1'b1);
    cyc(); chk("wrap_zero", 16'h6001, 16'h0001, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
